// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit controller: FSM states, slot/frame sizes
// and the stereo sample-pair record.
package i2s_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [SLOT_BITS-1:0] left;
        logic [SLOT_BITS-1:0] right;
    } pair_t;

endpackage

// File: rtl/i2s_tx_ctrl_if.sv
// Upstream valid/ready sample-pair stream feeding the I2S transmit controller.
interface i2s_tx_ctrl_if;
    import i2s_pkg::*;

    logic                 s_valid;
    logic                 s_ready;
    logic [SLOT_BITS-1:0] s_left;
    logic [SLOT_BITS-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/i2s_tx_fifo.sv
// Synchronous sample-pair FIFO; push is ignored when full, pop ignored when empty.
module i2s_tx_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  pair_t                i_wdata,
    output pair_t                o_rdata,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    pair_t         r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit frame scheduler: bclk/lrc generation, sample buffering, underrun status.
// Build option I2S_TX_CTRL_HOLD_LAST_EN: hold the last sample on underrun instead of muting.
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    i2s_tx_ctrl_if.slave                s_if,
    output logic                        sck_bclk,
    output logic                        ws_lrc,
    output logic [SLOT_BITS-1:0]        left_data,
    output logic [SLOT_BITS-1:0]        right_data,
    input  logic                        read_data_en,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    input  logic                        clr_status
);

`ifdef I2S_TX_CTRL_HOLD_LAST_EN
    localparam bit HOLD_LAST = 1'b1;
`else
    localparam bit HOLD_LAST = 1'b0;
`endif

    localparam int HW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [HW-1:0] HC_MAX = HW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BC_MAX = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] BC_HALF = BW'(SLOT_BITS);

    state_e               r_state;
    logic [HW-1:0]        r_hcnt;
    logic                 r_bclk;
    logic [BW-1:0]        r_bcnt;
    logic                 r_ws;
    logic [SLOT_BITS-1:0] r_left;
    logic [SLOT_BITS-1:0] r_right;
    logic                 r_urun;

    logic                 w_hwrap;
    logic                 w_fall;
    logic                 w_last;
    logic [BW-1:0]        w_bnext;
    logic                 w_start;
    logic                 w_rd;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_urun;
    logic                 w_full;
    logic                 w_empty;
    pair_t                w_head;
    pair_t                w_wdata;

    assign w_hwrap = (r_hcnt == HC_MAX);
    assign w_fall  = w_hwrap && r_bclk;
    assign w_last  = w_fall && (r_bcnt == BC_MAX);
    assign w_bnext = r_bcnt + 1'b1;
    assign w_start = (r_state == ST_IDLE) && enable && !w_empty;
    assign w_rd    = (r_state != ST_IDLE) && read_data_en;
    assign w_pop   = w_start || (w_rd && !w_empty);
    assign w_urun  = w_rd && w_empty;
    assign w_push  = s_if.s_valid && !w_full;
    assign w_wdata = {s_if.s_left, s_if.s_right};

    i2s_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // Counters free-run through RUN and DRAIN so re-enabling never glitches the clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_bclk  <= 1'b0;
            r_bcnt  <= '0;
            r_ws    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_start) begin
                r_state <= ST_RUN;
                r_ws    <= 1'b1;
            end
        end else if ((r_state == ST_DRAIN) && !enable && w_last) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_bclk  <= 1'b0;
            r_bcnt  <= '0;
            r_ws    <= 1'b0;
        end else begin
            r_state <= enable ? ST_RUN : ST_DRAIN;
            r_hcnt  <= w_hwrap ? '0 : r_hcnt + 1'b1;
            if (w_hwrap) r_bclk <= ~r_bclk;
            if (w_fall) begin
                r_bcnt <= w_bnext;
                r_ws   <= (w_bnext < BC_HALF);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left  <= '0;
            r_right <= '0;
            r_urun  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_left  <= w_head.left;
                r_right <= w_head.right;
            end else if (w_urun && !HOLD_LAST) begin
                r_left  <= '0;
                r_right <= '0;
            end
            if (w_urun)          r_urun <= 1'b1;
            else if (clr_status) r_urun <= 1'b0;
        end
    end

    assign s_if.s_ready = !w_full;
    assign sck_bclk     = r_bclk;
    assign ws_lrc       = r_ws;
    assign left_data    = r_left;
    assign right_data   = r_right;
    assign busy         = (r_state != ST_IDLE);
    assign underrun     = r_urun;

endmodule
